// File: rtl/tx8b10b_pkg.sv
// rtl/tx8b10b_pkg.sv - K-code constants, framer state encodings, CRC helper
// CRC states, constants and helper exist only when TX_CRC_EN is defined.
package tx8b10b_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_DATA = 3'd2,
    ST_EOF  = 3'd3
`ifdef TX_CRC_EN
    ,
    ST_CRCH = 3'd4,
    ST_CRCL = 3'd5
`endif
  } state_t;

`ifdef TX_CRC_EN
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // MSB-first CRC-16/CCITT-FALSE update for one byte
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ CRC_POLY) : {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

endpackage

// File: rtl/tx_ser10.sv
// rtl/tx_ser10.sv - bit-period divider and 10-bit MSB-first serialiser
// load is high on the last clock of the last bit of a symbol.
module tx_ser10 #(
  parameter logic [3:0] BIT_DIV = 4'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] code,
  output logic       load,
  output logic       ser_bit
);

  logic [3:0] div_q;
  logic [3:0] bit_q;
  logic [9:0] shreg_q;
  logic       period_end;

  assign period_end = (div_q == BIT_DIV - 4'd1);
  assign load       = period_end && (bit_q == 4'd9);
  assign ser_bit    = shreg_q[9];

  always_ff @(posedge clk) begin
    if (rst) begin
      // preset so the first clock after reset release is a load
      div_q   <= BIT_DIV - 4'd1;
      bit_q   <= 4'd9;
      shreg_q <= '0;
    end else if (period_end) begin
      div_q <= '0;
      if (load) begin
        bit_q   <= '0;
        shreg_q <= code;
      end else begin
        bit_q   <= bit_q + 4'd1;
        shreg_q <= {shreg_q[8:0], 1'b0};
      end
    end else begin
      div_q <= div_q + 4'd1;
    end
  end

endmodule

// File: rtl/tx_8b10b_framer.sv
// rtl/tx_8b10b_framer.sv - frames bytes as SOF/data/EOF with K28.5 idles, holds RD, drives serialiser
// Defining TX_CRC_EN appends a CRC-16/CCITT-FALSE (high, low byte) before EOF.
module tx_8b10b_framer
  import tx8b10b_pkg::*;
#(
  parameter logic [3:0] BIT_DIV  = 4'd1,
  parameter logic [3:0] MIN_IDLE = 4'd2
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [7:0] i_TxData,
  input  logic       i_TxValid,
  input  logic       i_TxLast,
  output logic       o_TxReady,
  output logic [7:0] o_EncData,
  output logic       o_EncK,
  output logic       o_EncDisp,
  input  logic [9:0] i_EncData10,
  input  logic       i_EncDisp,
  input  logic       i_EncKErr,
  output logic       o_SerBit,
  output logic       o_SymStrb,
  output logic       o_Underrun,
  output logic       o_KErr
);

  state_t     state_q, state_d;
  logic [3:0] idle_q, idle_d, idle_inc;
  logic       rd_q, kerr_q, strb_q, undr_q, undr_d;
  logic       load, ready;
  logic [7:0] sym_data;
  logic       sym_k;
`ifdef TX_CRC_EN
  logic [15:0] crc_q, crc_d;
`endif

  tx_ser10 #(.BIT_DIV(BIT_DIV)) u_ser (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .code    (i_EncData10),
    .load    (load),
    .ser_bit (o_SerBit)
  );

  assign idle_inc = (idle_q == 4'd15) ? idle_q : idle_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    idle_d   = idle_q;
    sym_data = K28_5;
    sym_k    = 1'b1;
    ready    = 1'b0;
    undr_d   = 1'b0;
`ifdef TX_CRC_EN
    crc_d    = crc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        idle_d = idle_inc;
        if ((idle_inc >= MIN_IDLE) && i_TxValid) state_d = ST_SOF;
      end
      ST_SOF: begin
        sym_data = K27_7;
        state_d  = ST_DATA;
`ifdef TX_CRC_EN
        crc_d    = CRC_INIT;
`endif
      end
      ST_DATA: begin
        ready = 1'b1;
        if (i_TxValid) begin
          sym_data = i_TxData;
          sym_k    = 1'b0;
`ifdef TX_CRC_EN
          crc_d    = crc16_byte(crc_q, i_TxData);
          if (i_TxLast) state_d = ST_CRCH;
`else
          if (i_TxLast) state_d = ST_EOF;
`endif
        end else begin
          // underrun: abort marker replaces the missing byte
          sym_data = K30_7;
          undr_d   = 1'b1;
          idle_d   = 4'd0;
          state_d  = ST_IDLE;
        end
      end
`ifdef TX_CRC_EN
      ST_CRCH: begin
        sym_data = crc_q[15:8];
        sym_k    = 1'b0;
        state_d  = ST_CRCL;
      end
      ST_CRCL: begin
        sym_data = crc_q[7:0];
        sym_k    = 1'b0;
        state_d  = ST_EOF;
      end
`endif
      ST_EOF: begin
        sym_data = K29_7;
        idle_d   = 4'd0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      idle_q  <= MIN_IDLE;
      rd_q    <= 1'b0;
      kerr_q  <= 1'b0;
      strb_q  <= 1'b0;
      undr_q  <= 1'b0;
`ifdef TX_CRC_EN
      crc_q   <= CRC_INIT;
`endif
    end else begin
      strb_q <= load;
      undr_q <= load && undr_d;
      if (load) begin
        state_q <= state_d;
        idle_q  <= idle_d;
        rd_q    <= i_EncDisp;
`ifdef TX_CRC_EN
        crc_q   <= crc_d;
`endif
        if (i_EncKErr) kerr_q <= 1'b1;
      end
    end
  end

  // the serialiser counters sit at a load position during reset, so gate the symbol path
  assign o_TxReady  = ready && load && !i_Rst;
  assign o_EncData  = i_Rst ? 8'h00 : sym_data;
  assign o_EncK     = sym_k && !i_Rst;
  assign o_EncDisp  = rd_q;
  assign o_SymStrb  = strb_q;
  assign o_Underrun = undr_q;
  assign o_KErr     = kerr_q;

endmodule

// File: tb/tb_tx_8b10b_framer.sv
// tb/tb_tx_8b10b_framer.sv - scoreboard bench for tx_8b10b_framer with a behavioural 8b/10b encoder
// Build with TX_CRC_EN defined to exercise the CRC trailer.
module tb_tx_8b10b_framer;

  localparam int MIN_IDLE_TB = 2;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       kerr_force = 1'b0;
  logic       tx_ready, enc_k, enc_disp, ser_bit, sym_strb, underrun, kerr;
  logic [7:0] enc_data;
  logic [10:0] enc_res;
  logic       d4_ready, d4_enc_k, d4_enc_disp, d4_ser, d4_strb, d4_underrun, d4_kerr;
  logic [7:0] d4_enc_data;
  logic [10:0] d4_res;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [5:0] tab6(input logic [4:0] x);
    case (x)
      5'd0:  tab6 = 6'b100111;  5'd1:  tab6 = 6'b011101;
      5'd2:  tab6 = 6'b101101;  5'd3:  tab6 = 6'b110001;
      5'd4:  tab6 = 6'b110101;  5'd5:  tab6 = 6'b101001;
      5'd6:  tab6 = 6'b011001;  5'd7:  tab6 = 6'b111000;
      5'd8:  tab6 = 6'b111001;  5'd9:  tab6 = 6'b100101;
      5'd10: tab6 = 6'b010101;  5'd11: tab6 = 6'b110100;
      5'd12: tab6 = 6'b001101;  5'd13: tab6 = 6'b101100;
      5'd14: tab6 = 6'b011100;  5'd15: tab6 = 6'b010111;
      5'd16: tab6 = 6'b011011;  5'd17: tab6 = 6'b100011;
      5'd18: tab6 = 6'b010011;  5'd19: tab6 = 6'b110010;
      5'd20: tab6 = 6'b001011;  5'd21: tab6 = 6'b101010;
      5'd22: tab6 = 6'b011010;  5'd23: tab6 = 6'b111010;
      5'd24: tab6 = 6'b110011;  5'd25: tab6 = 6'b100110;
      5'd26: tab6 = 6'b010110;  5'd27: tab6 = 6'b110110;
      5'd28: tab6 = 6'b001110;  5'd29: tab6 = 6'b101110;
      5'd30: tab6 = 6'b011110;  default: tab6 = 6'b101011;
    endcase
  endfunction

  function automatic logic [3:0] tab4(input logic [2:0] y);
    case (y)
      3'd0: tab4 = 4'b1011;  3'd1: tab4 = 4'b1001;
      3'd2: tab4 = 4'b0101;  3'd3: tab4 = 4'b1100;
      3'd4: tab4 = 4'b1101;  3'd5: tab4 = 4'b1010;
      3'd6: tab4 = 4'b0110;  default: tab4 = 4'b1110;
    endcase
  endfunction

  // returns {rd_out, abcdei, fghj}; rd 0 = RD-
  function automatic logic [10:0] enc8b10b(input logic [7:0] d, input logic k, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s6;
    logic [3:0] s4;
    logic rd6, alt;
    x = d[4:0];
    y = d[7:5];
    s6 = (k && x == 5'd28) ? 6'b001111 : tab6(x);
    if (rd && ($countones(s6) != 3 || x == 5'd7)) s6 = ~s6;
    rd6 = ($countones(s6) == 3) ? rd : ~rd;
    if (k) begin
      s4 = (y == 3'd7) ? 4'b0111 : tab4(y);
      if ($countones(s4) != 2 || y == 3'd3) s4 = ~s4;
      if (!rd6) s4 = ~s4;
    end else begin
      alt = (y == 3'd7) && ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                            (rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
      s4 = alt ? 4'b0111 : tab4(y);
      if (rd6 && ($countones(s4) != 2 || y == 3'd3)) s4 = ~s4;
    end
    return {($countones(s4) == 2) ? rd6 : ~rd6, s6, s4};
  endfunction

`ifdef TX_CRC_EN
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction
`endif

  assign enc_res = enc8b10b(enc_data, enc_k, enc_disp);
  assign d4_res  = enc8b10b(d4_enc_data, d4_enc_k, d4_enc_disp);

  tx_8b10b_framer #(.BIT_DIV(4'd1), .MIN_IDLE(4'd2)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_TxData(tx_data), .i_TxValid(tx_valid), .i_TxLast(tx_last),
    .o_TxReady(tx_ready), .o_EncData(enc_data), .o_EncK(enc_k), .o_EncDisp(enc_disp),
    .i_EncData10(enc_res[9:0]), .i_EncDisp(enc_res[10]), .i_EncKErr(kerr_force),
    .o_SerBit(ser_bit), .o_SymStrb(sym_strb), .o_Underrun(underrun), .o_KErr(kerr)
  );

  tx_8b10b_framer #(.BIT_DIV(4'd4), .MIN_IDLE(4'd2)) dut4 (
    .i_Clk(clk), .i_Rst(rst), .i_TxData(8'h00), .i_TxValid(1'b0), .i_TxLast(1'b0),
    .o_TxReady(d4_ready), .o_EncData(d4_enc_data), .o_EncK(d4_enc_k), .o_EncDisp(d4_enc_disp),
    .i_EncData10(d4_res[9:0]), .i_EncDisp(d4_res[10]), .i_EncKErr(1'b0),
    .o_SerBit(d4_ser), .o_SymStrb(d4_strb), .o_Underrun(d4_underrun), .o_KErr(d4_kerr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [8:0] sb[$];
  logic [7:0] payload[16];
  int ready_cnt = 0;
  int underrun_cnt = 0;

  // main monitor: symbols are taken from the negedge before each o_SymStrb pulse
  initial begin
    logic [7:0] prev_data;
    logic       prev_k, prev_disp, prev_rd_new, exp_rd, have_code;
    logic [9:0] prev_code, last_code, ser_acc;
    logic [8:0] exp_sym;
    int idle_seen, sym_idx;
    prev_data = '0; prev_k = 0; prev_disp = 0; prev_rd_new = 0; prev_code = '0;
    exp_rd = 0; have_code = 0; last_code = '0; ser_acc = '0; idle_seen = MIN_IDLE_TB; sym_idx = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_rd = 0; have_code = 0; ser_acc = '0; idle_seen = MIN_IDLE_TB; sym_idx = 0;
      end else begin
        if (sym_strb) begin
          if (have_code) check("ser_code", ser_acc, last_code);
          check("rd_in", prev_disp, exp_rd);
          exp_rd = prev_rd_new;
          last_code = prev_code;
          have_code = 1;
          if (sym_idx < 3) check("idle_code", prev_code, (sym_idx % 2 == 0) ? 10'h0FA : 10'h305);
          sym_idx++;
          if (prev_k && prev_data == K28_5) idle_seen++;
          else if (sb.size() == 0) check("sym_unexpected", {prev_k, prev_data}, {1'b1, K28_5});
          else begin
            exp_sym = sb.pop_front();
            check("sym", {prev_k, prev_data}, exp_sym);
            if (exp_sym == {1'b1, K27_7}) check("min_idle", idle_seen >= MIN_IDLE_TB, 1);
            if (exp_sym == {1'b1, K29_7} || exp_sym == {1'b1, K30_7}) idle_seen = 0;
          end
        end
        ser_acc = {ser_acc[8:0], ser_bit};
        if (tx_ready) ready_cnt++;
        if (underrun) underrun_cnt++;
      end
      prev_data = enc_data; prev_k = enc_k; prev_disp = enc_disp;
      prev_code = enc_res[9:0]; prev_rd_new = enc_res[10];
    end
  end

  // BIT_DIV=4 monitor: 40-clock symbols, line changes only on 4-clock boundaries
  initial begin
    int since, bad;
    logic have4, last_ser;
    logic [9:0] acc4, code4_last, prev4_code;
    since = 0; bad = 0; have4 = 0; last_ser = 0; acc4 = '0; code4_last = '0; prev4_code = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        since = 0; bad = 0; have4 = 0;
      end else begin
        if (d4_strb) begin
          if (have4) begin
            check("div4_period", since, 40);
            check("div4_hold", bad, 0);
            check("div4_code", acc4, code4_last);
          end
          have4 = 1; since = 0; bad = 0; acc4 = '0; code4_last = prev4_code;
        end
        if (since % 4 == 0) acc4 = {acc4[8:0], d4_ser};
        else if (d4_ser != last_ser) bad++;
        last_ser = d4_ser;
        since++;
      end
      prev4_code = d4_res[9:0];
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic send_frame(input int n, input bit drop);
    bit ok;
`ifdef TX_CRC_EN
    logic [15:0] c;
    c = 16'hFFFF;
`endif
    sb.push_back({1'b1, K27_7});
    for (int i = 0; i < n; i++) begin
      tx_data = payload[i];
      tx_valid = 1'b1;
      tx_last = (i == n - 1) && !drop;
      ok = 0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (tx_ready) begin ok = 1; break; end
      end
      check("ready_seen", ok, 1);
      sb.push_back({1'b0, payload[i]});
`ifdef TX_CRC_EN
      c = crc_upd(c, payload[i]);
`endif
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    tx_last = 1'b0;
    if (drop) begin
      sb.push_back({1'b1, K30_7});
      wait_drain();
    end else begin
`ifdef TX_CRC_EN
      sb.push_back({1'b0, c[15:8]});
      sb.push_back({1'b0, c[7:0]});
`endif
      sb.push_back({1'b1, K29_7});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {tx_ready, enc_data, enc_k, enc_disp, ser_bit, sym_strb, underrun, kerr}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("first_strb", sym_strb, 1);
    check("first_bit", ser_bit, 0);
    repeat (40) @(posedge clk); #1;

    ready_cnt = 0;
    payload[0] = 8'hB5;
    send_frame(1, 0);
    wait_drain();
    check("ready_once", ready_cnt, 1);
    check("no_underrun", underrun_cnt, 0);

    underrun_cnt = 0;
    payload[0] = 8'h11;
    send_frame(1, 1);
    payload[0] = 8'h33; payload[1] = 8'h44;
    send_frame(2, 0);
    wait_drain();
    check("underrun_pulses", underrun_cnt, 1);

    for (int i = 0; i < 5; i++) payload[i] = 8'($urandom_range(0, 255));
    send_frame(5, 0);
    wait_drain();

`ifdef TX_CRC_EN
    for (int i = 0; i < 9; i++) payload[i] = 8'h31 + 8'(i);
    send_frame(9, 0);
    wait_drain();
`endif

    repeat (12) @(posedge clk);
    @(negedge clk);
    check("kerr_pre", kerr, 0);
    @(posedge clk); #1 kerr_force = 1'b1;
    repeat (12) @(posedge clk);
    #1 kerr_force = 1'b0;
    @(negedge clk);
    check("kerr_set", kerr, 1);
    repeat (25) @(posedge clk);
    @(negedge clk);
    check("kerr_hold", kerr, 1);

    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset2_outs", {tx_ready, enc_data, enc_k, enc_disp, ser_bit, sym_strb, underrun, kerr}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (45) @(posedge clk);
    @(negedge clk);
    check("d4_quiet", {d4_ready, d4_underrun, d4_kerr}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
